fir_mac_sequencer: RTL and testbench

//  Time-multiplexed FIR controller. It shares one signed multiply-accumulate (MAC)
//  DSP slice across NTAPS taps. It accepts one input sample per transaction on a

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_mac_unit.sv | 68 ++++++
 rtl/fir_mac_sequencer.sv | 127 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

    localparam int unsigned DEF_NTAPS   = 3;
    localparam int unsigned DEF_DW      = 18;
    localparam int unsigned DEF_CW      = 18;
    localparam int unsigned DEF_AW      = 54;
    localparam int unsigned DEF_MUL_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_e;

    // Power-on / reset coefficient for tap k.
    function automatic int coef_default(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed MAC: registered operands, MUL_LAT-deep product pipeline, AW-bit
// wrapping accumulator with synchronous clear.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] a,
    input  logic signed [CW-1:0] b,
    output logic signed [AW-1:0] acc
);

    localparam int unsigned PW = DW + CW;

    logic signed [DW-1:0] a_q;
    logic signed [CW-1:0] b_q;
    logic                 v_q;
    logic signed [PW-1:0] prod_q [MUL_LAT];
    logic [MUL_LAT-1:0]   pv_q;
    logic signed [AW-1:0] acc_q;

    // Operand input registers (DSP A/B stage).
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
        end else begin
            a_q <= a;
            b_q <= b;
            v_q <= in_valid;
        end
    end

    // Full-precision product pipeline with a matching valid shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
            pv_q <= '0;
        end else begin
            prod_q[0] <= PW'(a_q) * PW'(b_q);
            pv_q[0]   <= v_q;
            for (int i = 1; i < MUL_LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
                pv_q[i]   <= pv_q[i-1];
            end
        end
    end

    // Accumulate sign-extended products; wraps modulo 2^AW.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
        end else if (pv_q[MUL_LAT-1]) begin
            acc_q <= acc_q + AW'(prod_q[MUL_LAT-1]);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC walks NTAPS taps per input sample.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS   = DEF_NTAPS,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DW-1:0]     s_data,
    input  logic                     cfg_we,
    input  logic [$clog2(NTAPS)-1:0] cfg_addr,
    input  logic signed [CW-1:0]     cfg_data,
    output logic                     cfg_err,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [AW-1:0]     m_data,
    output logic                     busy
);

    localparam int unsigned AddrW    = $clog2(NTAPS);
    // Last product needs the operand register plus MUL_LAT stages to reach the accumulator.
    localparam int unsigned DrainLen = MUL_LAT + 1;
    localparam int unsigned CntMax   = (NTAPS > DrainLen) ? NTAPS : DrainLen;
    localparam int unsigned CntW     = $clog2(CntMax);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q;
    logic [AddrW-1:0]     wr_ptr_q, newest_q, rd_idx, tap_idx;
    logic signed [DW-1:0] hist_q [NTAPS];
    logic signed [CW-1:0] coef_q [NTAPS];
    logic                 accept, cfg_ok, cfg_err_q;
    logic signed [AW-1:0] acc;

    assign accept  = (state_q == IDLE) && s_valid;
    assign cfg_ok  = (state_q == IDLE) && (32'(cfg_addr) < NTAPS);
    assign tap_idx = AddrW'(cnt_q);

    // History slot for x[n-k]: (newest - k) mod NTAPS.
    always_comb begin
        rd_idx = newest_q - tap_idx;
        if (tap_idx > newest_q) rd_idx = AddrW'(32'(newest_q) + NTAPS - 32'(tap_idx));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (s_valid) state_d = MAC;
            MAC:     if (32'(cnt_q) == NTAPS - 1) state_d = DRAIN;
            DRAIN:   if (32'(cnt_q) == DrainLen - 1) state_d = OUT;
            OUT:     if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        s_ready = (state_q == IDLE);
        busy    = (state_q != IDLE);
        m_valid = (state_q == OUT);
    end

    // Tap / drain cycle counter, restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) cnt_q <= '0;
        else                             cnt_q <= cnt_q + 1'b1;
    end

    // Circular sample history and write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) hist_q[i] <= '0;
            wr_ptr_q <= '0;
            newest_q <= '0;
        end else if (accept) begin
            hist_q[wr_ptr_q] <= s_data;
            newest_q         <= wr_ptr_q;
            wr_ptr_q         <= (32'(wr_ptr_q) == NTAPS - 1) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    // Coefficient register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= CW'(coef_default(i));
        end else if (cfg_we && cfg_ok) begin
            coef_q[cfg_addr] <= cfg_data;
        end
    end

    // One-cycle pulse for rejected coefficient writes.
    always_ff @(posedge clk) begin
        if (rst) cfg_err_q <= 1'b0;
        else     cfg_err_q <= cfg_we && !cfg_ok;
    end

    fir_mac_unit #(
        .DW      (DW),
        .CW      (CW),
        .AW      (AW),
        .MUL_LAT (MUL_LAT)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .in_valid (state_q == MAC),
        .a        (hist_q[rd_idx]),
        .b        (coef_q[tap_idx]),
        .acc      (acc)
    );

    assign m_data  = acc;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: stimulus pushes expected results,
// a monitor pops and compares whenever m_valid is presented.
module tb_fir_mac_sequencer;

    localparam int NT  = 3;
    localparam int DW  = 18;
    localparam int CW  = 18;
    localparam int AW  = 54;
    localparam int ML  = 1;
    localparam int LAT = NT + ML + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_data = '0;
    logic                 cfg_we = 1'b0;
    logic [1:0]           cfg_addr = '0;
    logic signed [CW-1:0] cfg_data = '0;
    logic                 cfg_err;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic signed [AW-1:0] m_data;
    logic                 busy;

    fir_mac_sequencer #(
        .NTAPS   (NT),
        .DW      (DW),
        .CW      (CW),
        .AW      (AW),
        .MUL_LAT (ML)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [AW-1:0] data;
        int                   cyc;
    } exp_t;

    exp_t   exp_q[$];
    longint hist_m[$];
    longint coef_m[NT];
    int     total = 0;
    int     bad = 0;
    bit     rand_ready = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: y[n] = sum_k x[n-k]*coef[k], wrapped to AW bits.
    task automatic model_reset();
        hist_m.delete();
        for (int k = 0; k < NT; k++) begin
            hist_m.push_back(0);
            coef_m[k] = k + 1;
        end
        exp_q.delete();
    endtask

    task automatic model_accept(input longint x, input int t);
        longint sum = 0;
        exp_t   e;
        hist_m.push_front(x);
        void'(hist_m.pop_back());
        for (int k = 0; k < NT; k++) sum += hist_m[k] * coef_m[k];
        e.data = AW'(sum);
        e.cyc  = t + LAT;
        exp_q.push_back(e);
    endtask

    // One stimulus cycle: optional sample and/or coefficient write.
    task automatic drive(input bit do_s, input logic signed [DW-1:0] x, input bit do_c,
                         input logic [1:0] a, input logic signed [CW-1:0] d, input bit wait_rdy);
        int w = 0;
        bit idle, ok;
        int t;
        @(negedge clk);
        if (wait_rdy) begin
            while (!s_ready && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!s_ready) begin
                check(s_ready, "s_ready_timeout", s_ready, 1);
                return;
            end
        end
        idle = s_ready;
        t = cyc + 1;
        s_valid = do_s; s_data = x;
        cfg_we = do_c; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        ok = idle && (a < NT);
        if (do_c && ok) coef_m[a] = longint'(d);
        if (do_s && idle) model_accept(longint'(x), t);
        @(negedge clk);
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        check(cfg_err == (do_c && !ok), "cfg_err", cfg_err, (do_c && !ok));
    endtask

    task automatic send(input logic signed [DW-1:0] x);
        drive(1'b1, x, 1'b0, 2'd0, '0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check(s_ready == 1'b1, "rst_s_ready", s_ready, 1);
        check(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
        check(m_data == '0, "rst_m_data", m_data, 0);
        check(cfg_err == 1'b0, "rst_cfg_err", cfg_err, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || !s_ready) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check(exp_q.size() == 0 && s_ready, "drain_timeout", exp_q.size(), 0);
    endtask

    task automatic set_ready(input bit r);
        @(posedge clk);
        #1 m_ready = r;
    endtask

    // Monitor: compares each presented result with the scoreboard head.
    bit                   showing = 1'b0;
    bit                   prev_hs = 1'b0;
    logic signed [AW-1:0] held;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                showing = 1'b0;
                prev_hs = 1'b0;
                continue;
            end
            if (prev_hs) check(m_valid == 1'b0, "m_valid_drop", m_valid, 0);
            prev_hs = 1'b0;
            if (m_valid) begin
                check(s_ready == 1'b0, "s_ready_in_out", s_ready, 0);
                if (!showing) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_m_valid", m_data, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check(m_data == e.data, "m_data", m_data, e.data);
                        check(cyc == e.cyc, "latency", cyc, e.cyc);
                    end
                    held = m_data;
                    showing = 1'b1;
                end else begin
                    check(m_data == held, "m_data_hold", m_data, held);
                end
                if (m_ready) begin
                    prev_hs = 1'b1;
                    showing = 1'b0;
                end
            end else begin
                showing = 1'b0;
            end
        end
    end

    // Random backpressure, changed just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Default coefficients 1,2,3: expect 5,17,30,23.
        send(5); send(7); send(1); send(0);
        drain();

        // Most-negative sample, sign extension across the full output.
        do_reset();
        send(-131072);
        drain();

        // Backpressure in OUT with s_valid held high.
        set_ready(1'b0);
        send(11);
        @(negedge clk);
        s_valid = 1'b1; s_data = 123;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check(s_ready == 1'b0, "s_ready_stall", s_ready, 0);
            check(busy == 1'b1, "busy_stall", busy, 1);
        end
        s_valid = 1'b0;
        set_ready(1'b1);
        drain();

        // Coefficient writes: IDLE accepted, MAC and out-of-range rejected.
        do_reset();
        drive(1'b0, '0, 1'b1, 2'd2, -1, 1'b1);
        send(1); send(1); send(1);
        drive(1'b0, '0, 1'b1, 2'd1, 99, 1'b0);
        drain();
        drive(1'b0, '0, 1'b1, 2'd3, 55, 1'b1);
        send(4);
        drain();

        // Same-cycle coefficient write and sample.
        do_reset();
        drive(1'b1, 2, 1'b1, 2'd0, 4, 1'b1);
        drain();

        // Reset mid-MAC abandons the transaction.
        send(3);
        @(negedge clk);
        do_reset();
        send(5);
        drain();

        // Randomized traffic with backpressure and coefficient writes.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0)
                drive(1'b0, '0, 1'b1, 2'($urandom_range(0, 3)), CW'($urandom),
                      1'($urandom_range(0, 1)));
            else
                drive(1'b1, DW'($urandom), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), CW'($urandom), 1'b1);
        end
        rand_ready = 1'b0;
        set_ready(1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
